// File: rtl/pipe_reg_chain.sv
// Chained E/M/W pipeline registers carrying payload plus tnew hazard metadata.
// Combinational youngest-match hazard detection and forwarding select.
module pipe_reg_chain #(
    parameter int DATA_W = 192,
    parameter int DEPTH  = 3,
    parameter int TNEW_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_rfwe,
    input  logic [4:0]               in_waddr,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic                     flush,
    input  logic                     freeze,
    input  logic [4:0]               q_addr_a,
    input  logic [4:0]               q_addr_b,
    input  logic [TNEW_W-1:0]        q_tuse_a,
    input  logic [TNEW_W-1:0]        q_tuse_b,
    output logic [DEPTH*DATA_W-1:0]  st_data,
    output logic [DEPTH-1:0]         st_valid,
    output logic [DEPTH-1:0]         st_rfwe,
    output logic [DEPTH*5-1:0]       st_waddr,
    output logic [DEPTH*TNEW_W-1:0]  st_tnew,
    output logic                     stall_req,
    output logic [3:0]               fwd_sel_a,
    output logic [3:0]               fwd_sel_b,
    output logic [CNT_W-1:0]         bubble_cnt
);

    logic [DATA_W-1:0] data_q  [DEPTH];
    logic              valid_q [DEPTH];
    logic              rfwe_q  [DEPTH];
    logic [4:0]        waddr_q [DEPTH];
    logic [TNEW_W-1:0] tnew_q  [DEPTH];

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k]  <= '0;
                valid_q[k] <= 1'b0;
                rfwe_q[k]  <= 1'b0;
                waddr_q[k] <= '0;
                tnew_q[k]  <= '0;
            end
        end else begin
            // flush takes stage 0 even while the rest of the chain is frozen
            if (flush) begin
                data_q[0]  <= '0;
                valid_q[0] <= 1'b0;
                rfwe_q[0]  <= 1'b0;
                waddr_q[0] <= '0;
                tnew_q[0]  <= '0;
            end else if (!freeze) begin
                data_q[0]  <= in_data;
                valid_q[0] <= in_valid;
                rfwe_q[0]  <= in_rfwe;
                waddr_q[0] <= in_waddr;
                tnew_q[0]  <= sat_dec(in_tnew);
            end
            if (!freeze) begin
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                    rfwe_q[k]  <= rfwe_q[k-1];
                    waddr_q[k] <= waddr_q[k-1];
                    tnew_q[k]  <= sat_dec(tnew_q[k-1]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (flush && in_valid && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign st_data[k*DATA_W +: DATA_W]  = data_q[k];
        assign st_valid[k]                  = valid_q[k];
        assign st_rfwe[k]                   = rfwe_q[k];
        assign st_waddr[k*5 +: 5]           = waddr_q[k];
        assign st_tnew[k*TNEW_W +: TNEW_W]  = tnew_q[k];
    end

    logic              hit_a;
    logic              hit_b;
    logic [3:0]        idx_a;
    logic [3:0]        idx_b;
    logic [TNEW_W-1:0] tn_a;
    logic [TNEW_W-1:0] tn_b;

    // scan oldest to youngest so the youngest match is the last one written
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx_a = 4'hF;
        idx_b = 4'hF;
        tn_a  = '0;
        tn_b  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && rfwe_q[k] && waddr_q[k] != 5'd0) begin
                if (waddr_q[k] == q_addr_a) begin
                    hit_a = 1'b1;
                    idx_a = 4'(k);
                    tn_a  = tnew_q[k];
                end
                if (waddr_q[k] == q_addr_b) begin
                    hit_b = 1'b1;
                    idx_b = 4'(k);
                    tn_b  = tnew_q[k];
                end
            end
        end
    end

    assign stall_req = (hit_a && tn_a > q_tuse_a) || (hit_b && tn_b > q_tuse_b);
    assign fwd_sel_a = (hit_a && tn_a == '0) ? idx_a : 4'hF;
    assign fwd_sel_b = (hit_b && tn_b == '0) ? idx_b : 4'hF;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: flow, flush, freeze, hazard, reset.
// A second narrow instance with CNT_W=2 shows bubble counter saturation.
module tb_pipe_reg_chain;

    localparam int DW = 192;
    localparam int D  = 3;
    localparam int TW = 3;

    localparam logic [DW-1:0] P1 = {6{32'hCAFE_0001}};
    localparam logic [DW-1:0] P2 = {6{32'h1234_ABCD}};
    localparam logic [DW-1:0] P3 = {6{32'h0F0F_5A5A}};

    logic            clk;
    logic            reset;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_rfwe;
    logic [4:0]      in_waddr;
    logic [TW-1:0]   in_tnew;
    logic            flush;
    logic            freeze;
    logic [4:0]      q_addr_a;
    logic [4:0]      q_addr_b;
    logic [TW-1:0]   q_tuse_a;
    logic [TW-1:0]   q_tuse_b;
    logic [D*DW-1:0] st_data;
    logic [D-1:0]    st_valid;
    logic [D-1:0]    st_rfwe;
    logic [D*5-1:0]  st_waddr;
    logic [D*TW-1:0] st_tnew;
    logic            stall_req;
    logic [3:0]      fwd_sel_a;
    logic [3:0]      fwd_sel_b;
    logic [15:0]     bubble_cnt;

    logic [D*8-1:0]  s_data;
    logic [D-1:0]    s_valid;
    logic [D-1:0]    s_rfwe;
    logic [D*5-1:0]  s_waddr;
    logic [D*TW-1:0] s_tnew;
    logic            s_stall;
    logic [3:0]      s_fwd_a;
    logic [3:0]      s_fwd_b;
    logic [1:0]      s_bubble;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_reg_chain #(.DATA_W(DW), .DEPTH(D), .TNEW_W(TW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_rfwe(in_rfwe), .in_waddr(in_waddr), .in_tnew(in_tnew),
        .flush(flush), .freeze(freeze),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .q_tuse_a(q_tuse_a), .q_tuse_b(q_tuse_b),
        .st_data(st_data), .st_valid(st_valid), .st_rfwe(st_rfwe),
        .st_waddr(st_waddr), .st_tnew(st_tnew), .stall_req(stall_req),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .bubble_cnt(bubble_cnt)
    );

    pipe_reg_chain #(.DATA_W(8), .DEPTH(D), .TNEW_W(TW), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_rfwe(in_rfwe), .in_waddr(in_waddr), .in_tnew(in_tnew),
        .flush(flush), .freeze(freeze),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .q_tuse_a(q_tuse_a), .q_tuse_b(q_tuse_b),
        .st_data(s_data), .st_valid(s_valid), .st_rfwe(s_rfwe),
        .st_waddr(s_waddr), .st_tnew(s_tnew), .stall_req(s_stall),
        .fwd_sel_a(s_fwd_a), .fwd_sel_b(s_fwd_b), .bubble_cnt(s_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW-1:0] tn(input int k);
        return st_tnew[k*TW +: TW];
    endfunction

    function automatic logic [4:0] wa(input int k);
        return st_waddr[k*5 +: 5];
    endfunction

    function automatic logic [DW-1:0] dat(input int k);
        return st_data[k*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [4:0] a,
                         input logic [TW-1:0] t, input logic [DW-1:0] d);
        in_valid = v;
        in_rfwe  = r;
        in_waddr = a;
        in_tnew  = t;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        freeze = 1'b0;
        q_addr_a = '0;
        q_addr_b = '0;
        q_tuse_a = '0;
        q_tuse_b = '0;
        drive(0, 0, 0, 0, '0);
        #3;
        check("rst_valid", DW'(st_valid), '0);
        check("rst_tnew", DW'(st_tnew), '0);
        check("rst_bubble", DW'(bubble_cnt), '0);
        check("rst_stall", DW'(stall_req), '0);
        check("rst_fwd_a", DW'(fwd_sel_a), DW'(4'hF));
        #9 reset = 1'b1;

        // flow
        drive(1, 1, 5, 3, P1);
        tick();
        check("flow_s0_tnew", DW'(tn(0)), DW'(2));
        check("flow_s0_valid", DW'(st_valid[0]), DW'(1));
        check("flow_s0_waddr", DW'(wa(0)), DW'(5));
        drive(0, 0, 0, 0, '0);
        tick();
        check("flow_s1_tnew", DW'(tn(1)), DW'(1));
        check("flow_s0_empty", DW'(st_valid[0]), '0);
        tick();
        check("flow_s2_tnew", DW'(tn(2)), '0);
        check("flow_s2_data", dat(2), P1);
        check("flow_s2_waddr", DW'(wa(2)), DW'(5));

        // flush
        drive(1, 1, 6, 2, P2);
        tick();
        drive(1, 1, 7, 3, P3);
        flush = 1'b1;
        tick();
        check("fl_s0_valid", DW'(st_valid[0]), '0);
        check("fl_s0_data", dat(0), '0);
        check("fl_s0_waddr", DW'(wa(0)), '0);
        check("fl_s0_tnew", DW'(tn(0)), '0);
        check("fl_s1_waddr", DW'(wa(1)), DW'(6));
        check("fl_s1_tnew", DW'(tn(1)), '0);
        tick();
        check("fl_bubble", DW'(bubble_cnt), DW'(2));
        check("fl_bubble_s", DW'(s_bubble), DW'(2));
        check("fl_s2_waddr", DW'(wa(2)), DW'(6));
        check("fl_s2_data", dat(2), P2);
        check("fl_s1_valid", DW'(st_valid[1]), '0);
        flush = 1'b0;

        // freeze
        drive(1, 1, 10, 3, P3);
        tick();
        drive(1, 1, 11, 1, P1);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_s0_tnew", DW'(tn(0)), DW'(2));
            check("fz_s0_waddr", DW'(wa(0)), DW'(10));
        end
        check("fz_valid", DW'(st_valid), DW'(3'b001));
        check("fz_bubble", DW'(bubble_cnt), DW'(2));
        freeze = 1'b0;
        drive(1, 1, 12, 3, P2);
        tick();
        check("fz_rel_s1_tnew", DW'(tn(1)), DW'(1));
        check("fz_rel_s1_data", dat(1), P3);
        check("fz_rel_s0_waddr", DW'(wa(0)), DW'(12));
        freeze = 1'b1;
        flush = 1'b1;
        drive(0, 0, 0, 0, '0);
        tick();
        check("fzfl_s0_valid", DW'(st_valid[0]), '0);
        check("fzfl_s0_waddr", DW'(wa(0)), '0);
        check("fzfl_s1_waddr", DW'(wa(1)), DW'(10));
        check("fzfl_s1_tnew", DW'(tn(1)), DW'(1));
        check("fzfl_bubble", DW'(bubble_cnt), DW'(2));
        freeze = 1'b0;
        flush = 1'b0;

        // hazard
        drive(1, 1, 8, 2, P1);
        tick();
        drive(0, 0, 0, 0, '0);
        q_addr_a = 5'd8;
        q_tuse_a = 3'd0;
        #1;
        check("hz_stall", DW'(stall_req), DW'(1));
        check("hz_fwd_a", DW'(fwd_sel_a), DW'(4'hF));
        q_tuse_a = 3'd1;
        #1;
        check("hz_tuse1_stall", DW'(stall_req), '0);
        q_tuse_a = 3'd0;
        drive(1, 1, 9, 2, P2);
        tick();
        drive(0, 0, 0, 0, '0);
        #1;
        check("hz_fwd_stall", DW'(stall_req), '0);
        check("hz_fwd_a1", DW'(fwd_sel_a), DW'(4'h1));
        q_addr_b = 5'd9;
        q_tuse_b = 3'd0;
        #1;
        check("hz_b_stall", DW'(stall_req), DW'(1));
        check("hz_b_fwd", DW'(fwd_sel_b), DW'(4'hF));
        q_addr_a = '0;
        q_addr_b = '0;

        // register zero and priority
        drive(1, 1, 4, 1, P1);
        tick();
        drive(1, 1, 0, 3, P2);
        tick();
        drive(1, 1, 4, 1, P3);
        tick();
        drive(0, 0, 0, 0, '0);
        q_addr_a = 5'd4;
        q_addr_b = 5'd0;
        #1;
        check("pr_fwd_a", DW'(fwd_sel_a), '0);
        check("r0_fwd_b", DW'(fwd_sel_b), DW'(4'hF));
        check("r0_stall", DW'(stall_req), '0);
        q_addr_a = '0;

        // bubble counting and saturation
        drive(1, 1, 3, 0, P1);
        flush = 1'b1;
        repeat (3) tick();
        check("bc_5", DW'(bubble_cnt), DW'(5));
        check("bc_sat", DW'(s_bubble), DW'(3));
        in_valid = 1'b0;
        tick();
        check("bc_noval", DW'(bubble_cnt), DW'(5));
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(i + 1), 2, P1);
            tick();
        end
        check("full_valid", DW'(st_valid), DW'(3'b111));
        drive(0, 0, 0, 0, '0);

        // asynchronous reset between edges
        #3 reset = 1'b0;
        #1;
        check("ar_valid", DW'(st_valid), '0);
        check("ar_rfwe", DW'(st_rfwe), '0);
        check("ar_waddr", DW'(st_waddr), '0);
        check("ar_tnew", DW'(st_tnew), '0);
        check("ar_s2_data", dat(2), '0);
        check("ar_bubble", DW'(bubble_cnt), '0);
        check("ar_bubble_s", DW'(s_bubble), '0);
        freeze = 1'b1;
        flush = 1'b1;
        drive(1, 1, 7, 2, P2);
        tick();
        check("ar_hold_valid", DW'(st_valid), '0);
        check("ar_hold_bubble", DW'(bubble_cnt), '0);
        #2 reset = 1'b1;
        freeze = 1'b0;
        flush = 1'b0;
        drive(1, 1, 13, 0, P2);
        tick();
        check("post_s0_valid", DW'(st_valid[0]), DW'(1));
        check("post_s0_waddr", DW'(wa(0)), DW'(13));
        check("post_s0_tnew", DW'(tn(0)), '0);
        check("post_s0_data", dat(0), P2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
